// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer capture controller.
// Holds the controller state encoding, the dump sub-phase encoding and the
// default host command bytes.
package la_pkg;

    // Controller state; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DUMP    = 2'd3
    } state_t;

    // Dump sub-phase: issue a FIFO read, wait for its data, hold it on tx.
    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_WAIT  = 2'd1,
        PH_SEND  = 2'd2
    } dump_ph_t;

    localparam logic [7:0] DEF_ARM_CMD   = 8'h30;
    localparam logic [7:0] DEF_ABORT_CMD = 8'h78;

endpackage

// File: rtl/la_trigger.sv
// Probe input register and masked trigger compare.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   probes           - raw signals under observation
//   trig_mask        - 1 = bit takes part in the compare
//   trig_value       - required value of the masked bits
//   probes_q         - probes delayed by one cycle (registered)
//   match_c          - combinational compare of probes_q against mask/value
module la_trigger #(
    parameter int unsigned SAMPLE_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] probes,
    input  logic [SAMPLE_WIDTH-1:0] trig_mask,
    input  logic [SAMPLE_WIDTH-1:0] trig_value,
    output logic [SAMPLE_WIDTH-1:0] probes_q,
    output logic                    match_c
);

    // Single synchronising stage; everything downstream sees probes_q only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probes_q <= '0;
        end else begin
            probes_q <= probes;
        end
    end

    // An all-zero mask always matches.
    always_comb begin
        match_c = (((probes_q ^ trig_value) & trig_mask) == '0);
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer sequencing controller: decodes arm/abort host bytes, waits
// for a masked trigger, writes FIFO_DEPTH consecutive samples to the FIFO and
// then drains the FIFO to the UART transmitter one byte per sample.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   rx_data, rx_valid        - host command byte and its strobe
//   probes                   - signals under observation
//   trig_mask, trig_value    - trigger compare mask and required value
//   fifo_clr                 - one-cycle FIFO flush pulse
//   fifo_wr_en, fifo_wr_data - FIFO write strobe and sample
//   fifo_full                - FIFO full flag (protocol check only)
//   fifo_rd_en, fifo_rd_data - FIFO read strobe and data (1-cycle latency)
//   fifo_empty               - FIFO empty flag
//   tx_data, tx_valid, tx_ready - UART transmit handshake
//   state_o                  - current controller state
//   done                     - one-cycle pulse when a dump completes
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 64,
    parameter int unsigned SAMPLE_WIDTH = 3,
    parameter logic [7:0]  ARM_CMD      = DEF_ARM_CMD,
    parameter logic [7:0]  ABORT_CMD    = DEF_ABORT_CMD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic [SAMPLE_WIDTH-1:0] probes,
    input  logic [SAMPLE_WIDTH-1:0] trig_mask,
    input  logic [SAMPLE_WIDTH-1:0] trig_value,
    output logic                    fifo_clr,
    output logic                    fifo_wr_en,
    output logic [SAMPLE_WIDTH-1:0] fifo_wr_data,
    input  logic                    fifo_full,
    output logic                    fifo_rd_en,
    input  logic [SAMPLE_WIDTH-1:0] fifo_rd_data,
    input  logic                    fifo_empty,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [1:0]              state_o,
    output logic                    done
);

    localparam int unsigned         CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    state_t                  state, state_d;
    dump_ph_t                phase, phase_d;
    logic [CNT_W-1:0]        count, count_d;
    logic                    abort_pend, abort_pend_d;
    logic [SAMPLE_WIDTH-1:0] probes_q;
    logic                    match_c;

    logic                    fifo_clr_d, fifo_wr_en_d, fifo_rd_en_d, tx_valid_d, done_d;
    logic [SAMPLE_WIDTH-1:0] fifo_wr_data_d;
    logic [7:0]              tx_data_d;

    logic arm_req_c, abort_req_c, abort_hit_c, room_c;

    la_trigger #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_trigger (
        .clk        (clk),
        .rst        (rst),
        .probes     (probes),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .probes_q   (probes_q),
        .match_c    (match_c)
    );

    // Command decode; an abort seen earlier in DUMP stays pending until the
    // in-flight byte has been accepted.
    always_comb begin
        arm_req_c   = rx_valid && (rx_data == ARM_CMD);
        abort_req_c = rx_valid && (rx_data == ABORT_CMD);
        abort_hit_c = abort_req_c || abort_pend;
        room_c      = (count < DEPTH_CNT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= PH_FETCH;
            count        <= '0;
            abort_pend   <= 1'b0;
            fifo_clr     <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            fifo_rd_en   <= 1'b0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            phase        <= phase_d;
            count        <= count_d;
            abort_pend   <= abort_pend_d;
            fifo_clr     <= fifo_clr_d;
            fifo_wr_en   <= fifo_wr_en_d;
            fifo_wr_data <= fifo_wr_data_d;
            fifo_rd_en   <= fifo_rd_en_d;
            tx_data      <= tx_data_d;
            tx_valid     <= tx_valid_d;
            done         <= done_d;
        end
    end

    assign state_o = state;

    // Next-state logic.
    always_comb begin
        state_d      = state;
        phase_d      = phase;
        count_d      = count;
        abort_pend_d = abort_pend;
        case (state)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (arm_req_c) state_d = ARMED;
            end
            ARMED: begin
                if (abort_req_c) begin
                    state_d = IDLE;
                end else if (match_c) begin
                    state_d = CAPTURE;
                    count_d = CNT_W'(1);
                end
            end
            CAPTURE: begin
                if (abort_req_c) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (room_c) begin
                    count_d = count + CNT_W'(1);
                end else begin
                    state_d = DUMP;
                    phase_d = PH_FETCH;
                    count_d = '0;
                end
            end
            default: begin // DUMP
                if (abort_req_c) abort_pend_d = 1'b1;
                case (phase)
                    PH_FETCH: begin
                        if (abort_hit_c || fifo_empty) begin
                            state_d      = IDLE;
                            abort_pend_d = 1'b0;
                        end else if (!tx_valid) begin
                            phase_d = PH_WAIT;
                        end
                    end
                    // First WAIT cycle has the read strobe up; data lands on the second.
                    PH_WAIT: begin
                        if (!fifo_rd_en) phase_d = PH_SEND;
                    end
                    default: begin // PH_SEND
                        if (tx_ready) begin
                            if (abort_hit_c || fifo_empty) begin
                                state_d      = IDLE;
                                phase_d      = PH_FETCH;
                                abort_pend_d = 1'b0;
                            end else begin
                                phase_d = PH_WAIT;
                            end
                        end
                    end
                endcase
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        fifo_clr_d     = 1'b0;
        fifo_wr_en_d   = 1'b0;
        fifo_wr_data_d = fifo_wr_data;
        fifo_rd_en_d   = 1'b0;
        tx_data_d      = tx_data;
        tx_valid_d     = tx_valid;
        done_d         = 1'b0;
        case (state)
            IDLE: begin
                if (arm_req_c) fifo_clr_d = 1'b1;
            end
            ARMED, CAPTURE: begin
                if (abort_req_c) begin
                    fifo_clr_d = 1'b1;
                end else if ((state == ARMED) ? match_c : room_c) begin
                    fifo_wr_en_d   = 1'b1;
                    fifo_wr_data_d = probes_q;
                end
            end
            default: begin // DUMP
                case (phase)
                    PH_FETCH: begin
                        if (abort_hit_c)     fifo_clr_d   = 1'b1;
                        else if (fifo_empty) done_d       = 1'b1;
                        else if (!tx_valid)  fifo_rd_en_d = 1'b1;
                    end
                    PH_WAIT: begin
                        if (!fifo_rd_en) begin
                            tx_data_d  = 8'(fifo_rd_data);
                            tx_valid_d = 1'b1;
                        end
                    end
                    default: begin // PH_SEND: accept edge may also issue the next read
                        if (tx_ready) begin
                            tx_valid_d = 1'b0;
                            if (abort_hit_c)     fifo_clr_d   = 1'b1;
                            else if (fifo_empty) done_d       = 1'b1;
                            else                 fifo_rd_en_d = 1'b1;
                        end
                    end
                endcase
            end
        endcase
    end

    // Writing into a full FIFO means the FIFO is undersized for FIFO_DEPTH.
    assert property (@(posedge clk) disable iff (rst) !(fifo_wr_en && fifo_full));

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Self-checking bench for la_capture_ctrl with a behavioural sample FIFO.
module tb_la_capture_ctrl;

    localparam int unsigned DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [2:0] probes = '0;
    logic [2:0] trig_mask = '0;
    logic [2:0] trig_value = '0;
    logic       fifo_clr, fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
    logic [2:0] fifo_wr_data;
    logic [2:0] fifo_rd_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [1:0] state_o;
    logic       done;

    int checks = 0;
    int errors = 0;

    la_capture_ctrl #(
        .FIFO_DEPTH   (DEPTH),
        .SAMPLE_WIDTH (3),
        .ARM_CMD      (8'h30),
        .ABORT_CMD    (8'h78)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .probes       (probes),
        .trig_mask    (trig_mask),
        .trig_value   (trig_value),
        .fifo_clr     (fifo_clr),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .state_o      (state_o),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: read data appears the cycle after fifo_rd_en.
    logic [2:0] fmem [DEPTH];
    int fcnt = 0, fwp = 0, frp = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= 0; fwp <= 0; frp <= 0; fifo_rd_data <= '0;
        end else if (fifo_clr) begin
            fcnt <= 0; fwp <= 0; frp <= 0;
        end else begin
            if (fifo_wr_en && fcnt < DEPTH) begin
                fmem[fwp] <= fifo_wr_data;
                fwp <= (fwp + 1) % DEPTH;
            end
            if (fifo_rd_en && fcnt > 0) begin
                fifo_rd_data <= fmem[frp];
                frp <= (frp + 1) % DEPTH;
            end
            fcnt <= fcnt + ((fifo_wr_en && fcnt < DEPTH) ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
        end
    end
    assign fifo_full  = (fcnt >= DEPTH);
    assign fifo_empty = (fcnt == 0);

    // Monitor, sampled on the falling edge.
    logic [2:0] wr_q [$];
    logic [7:0] tx_q [$];
    int cyc_n = 0, wr_first = 0, wr_last = 0;
    int clr_cnt = 0, done_cnt = 0, rd_cnt = 0, txv_cnt = 0;
    logic prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (!tx_valid || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL tx_hold: valid=%0b data=%0h, required valid=1 data=%0h", tx_valid, tx_data, prev_data);
                end
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (fifo_wr_en) begin
                if (wr_q.size() == 0) wr_first = cyc_n;
                wr_last = cyc_n;
                wr_q.push_back(fifo_wr_data);
            end
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            if (fifo_clr)   clr_cnt++;
            if (done)       done_cnt++;
            if (fifo_rd_en) rd_cnt++;
            if (tx_valid)   txv_cnt++;
            cyc_n++;
        end
    end

    logic probe_run = 1'b0;
    logic rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (probe_run)  probes = probes + 3'd1;
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_logs();
        wr_q.delete(); tx_q.delete();
        clr_cnt = 0; done_cnt = 0; rd_cnt = 0; txv_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            cyc();
            n++;
        end
        check("done_within_budget", 32'(done_cnt != 0), 1);
    endtask

    task automatic wait_tx_valid(input int budget);
        int n = 0;
        while (!tx_valid && n < budget) begin
            cyc();
            n++;
        end
        check("tx_valid_seen", 32'(tx_valid), 1);
    endtask

    task automatic arm(output logic [2:0] p0);
        cyc();
        rx_valid = 1'b1;
        rx_data  = 8'h30;
        p0 = probes;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic check_dump(input logic [2:0] first);
        logic [2:0] e;
        check("wr_count", 32'(wr_q.size()), DEPTH);
        check("wr_gapless", 32'(wr_last - wr_first + 1), DEPTH);
        check("tx_count", 32'(tx_q.size()), DEPTH);
        for (int i = 0; i < wr_q.size(); i++) begin
            e = first + 3'(i);
            check($sformatf("wr_data[%0d]", i), 32'(wr_q[i]), 32'(e));
        end
        for (int i = 0; i < tx_q.size(); i++) begin
            e = first + 3'(i);
            check($sformatf("tx_byte[%0d]", i), 32'(tx_q[i]), {29'd0, e});
        end
        check("done_pulses", 32'(done_cnt), 1);
        check("rd_pulses", 32'(rd_cnt), DEPTH);
        check("state_idle_after_dump", 32'(state_o), 0);
    endtask

    typedef struct {
        logic       rxv;
        logic [7:0] rxd;
        logic [2:0] prb;
        logic [1:0] st;
        logic       clr;
        logic       wr;
        logic [2:0] wd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [2:0] p0;

        // Per-edge vectors: mask 111, value 101, probes walking from 0.
        vecs[0] = '{1'b1, 8'h55, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 8'h78, 3'd1, 2'd0, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{1'b1, 8'h30, 3'd2, 2'd1, 1'b1, 1'b0, 3'd0};
        vecs[3] = '{1'b0, 8'h00, 3'd3, 2'd1, 1'b0, 1'b0, 3'd0};
        vecs[4] = '{1'b1, 8'h30, 3'd4, 2'd1, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{1'b0, 8'h00, 3'd5, 2'd1, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{1'b0, 8'h00, 3'd6, 2'd2, 1'b0, 1'b1, 3'd5};
        vecs[7] = '{1'b0, 8'h00, 3'd7, 2'd2, 1'b0, 1'b1, 3'd6};
        vecs[8] = '{1'b0, 8'h00, 3'd0, 2'd2, 1'b0, 1'b1, 3'd7};
        vecs[9] = '{1'b0, 8'h00, 3'd1, 2'd2, 1'b0, 1'b1, 3'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state_o), 0);
        check("rst_outputs", {24'd0, fifo_clr, fifo_wr_en, fifo_rd_en, tx_valid, done, fifo_wr_data}, 0);
        check("rst_tx_data", 32'(tx_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_rst", 32'(state_o), 0);
        clear_logs();

        // Masked trigger, table-driven
        trig_mask  = 3'b111;
        trig_value = 3'b101;
        for (int i = 0; i < 10; i++) begin
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            probes   = vecs[i].prb;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("vec%0d_clr", i), 32'(fifo_clr), 32'(vecs[i].clr));
            check($sformatf("vec%0d_wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].wr));
            check($sformatf("vec%0d_wr_data", i), 32'(fifo_wr_data), 32'(vecs[i].wd));
        end
        rx_valid  = 1'b0;
        probes    = probes + 3'd1;
        probe_run = 1'b1;
        tx_ready  = 1'b1;
        wait_done(800);
        repeat (3) cyc();
        check_dump(3'd5);
        check("clr_pulses_t1", 32'(clr_cnt), 1);

        // All-zero mask, randomly throttled transmitter
        clear_logs();
        trig_mask = 3'b000;
        tx_ready  = 1'b0;
        arm(p0);
        check("m0_armed", 32'(state_o), 1);
        check("m0_clr", 32'(fifo_clr), 1);
        check("m0_no_wr_yet", 32'(fifo_wr_en), 0);
        cyc();
        check("m0_capture", 32'(state_o), 2);
        check("m0_first_wr", 32'(fifo_wr_en), 1);
        check("m0_first_data", 32'(fifo_wr_data), 32'(p0));
        rand_ready = 1'b1;
        wait_done(2000);
        rand_ready = 1'b0;
        tx_ready   = 1'b0;
        repeat (3) cyc();
        check_dump(p0);

        // Abort after 20 writes
        clear_logs();
        begin
            int n = 0;
            int guard = 0;
            arm(p0);
            while (n < 20 && guard < 200) begin
                cyc();
                guard++;
                if (fifo_wr_en) n++;
            end
            check("abort_reached_20", 32'(n), 20);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h78;
        cyc();
        rx_valid = 1'b0;
        check("abort_wr_low", 32'(fifo_wr_en), 0);
        check("abort_clr", 32'(fifo_clr), 1);
        check("abort_state", 32'(state_o), 0);
        repeat (150) cyc();
        check("abort_wr_total", 32'(wr_q.size()), 20);
        check("abort_no_tx", 32'(txv_cnt), 0);
        check("abort_no_done", 32'(done_cnt), 0);
        check("abort_clr_pulses", 32'(clr_cnt), 2);

        // Abort during DUMP with a byte pending
        clear_logs();
        arm(p0);
        wait_tx_valid(300);
        rx_valid = 1'b1;
        rx_data  = 8'h78;
        cyc();
        rx_valid = 1'b0;
        repeat (3) cyc();
        check("dabort_hold_state", 32'(state_o), 3);
        check("dabort_hold_valid", 32'(tx_valid), 1);
        check("dabort_hold_data", 32'(tx_data), {24'd0, 5'd0, p0});
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
        check("dabort_valid_low", 32'(tx_valid), 0);
        check("dabort_clr", 32'(fifo_clr), 1);
        check("dabort_state", 32'(state_o), 0);
        repeat (5) cyc();
        check("dabort_one_byte", 32'(tx_q.size()), 1);
        check("dabort_no_done", 32'(done_cnt), 0);

        // Asynchronous reset mid-DUMP, then a normal re-arm
        clear_logs();
        arm(p0);
        wait_tx_valid(300);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state_o), 0);
        check("arst_outputs", {24'd0, fifo_clr, fifo_wr_en, fifo_rd_en, tx_valid, done, fifo_wr_data}, 0);
        check("arst_tx_data", 32'(tx_data), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        arm(p0);
        check("rearm_state", 32'(state_o), 1);
        check("rearm_clr", 32'(fifo_clr), 1);
        tx_ready = 1'b1;
        wait_done(800);
        repeat (3) cyc();
        check_dump(p0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
